// File: rtl/onchip_ram_dual.sv
// onchip_ram_dual: true dual-port on-chip RAM with byte enables, a 1- or
// 2-cycle read pipeline that freezes with the clock enable, same-address
// write collision counting and sticky out-of-range flags.
//
// Ports:
//   clk, reset            clock (rising edge) and asynchronous active-high reset
//   reset_req             blocks all accesses while high
//   clken                 global clock enable
//   sN_address            word address (N = 1, 2)
//   sN_chipselect         port select
//   sN_read / sN_write    read / write requests (write wins if both are high)
//   sN_byteenable         byte-lane enables for writes
//   sN_writedata          write data
//   sN_readdata           read data, held between returns
//   sN_readdatavalid      one-cycle read-return strobe
//   collision_count       saturating count of same-address write collisions
//   oob_error             sticky out-of-range flags, bit 0 = port 1, bit 1 = port 2
module onchip_ram_dual #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 14,
  parameter int DEPTH        = 12000,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic [15:0]             collision_count,
  output logic [1:0]              oob_error
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < (ADDR_WIDTH+1)'(DEPTH);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Zero-initialised storage; reset never touches it.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic                  en;
  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [BE_W-1:0]       be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [1:0]            cs, rd_req, wr_req;
  logic [IDX_W-1:0]      idx   [2];
  logic [1:0]            hit, wr_acc, rd_acc;
  logic                  collide;

  assign en       = clken & ~reset_req;
  assign addr[0]  = s1_address;
  assign addr[1]  = s2_address;
  assign be[0]    = s1_byteenable;
  assign be[1]    = s2_byteenable;
  assign wdata[0] = s1_writedata;
  assign wdata[1] = s2_writedata;
  assign cs       = {s2_chipselect, s1_chipselect};
  assign rd_req   = {s2_read, s1_read};
  assign wr_req   = {s2_write, s1_write};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hit[p]    = in_range(addr[p]);
      idx[p]    = addr[p][IDX_W-1:0];
      wr_acc[p] = en & ~reset & cs[p] & wr_req[p];
      rd_acc[p] = en & ~reset & cs[p] & rd_req[p] & ~wr_req[p];
    end
    collide = wr_acc[0] & wr_acc[1] & hit[0] & hit[1] & (addr[0] == addr[1]);
  end

  // Storage write; on a same-address collision port 2 is dropped entirely so
  // port 1 owns every lane, including lanes port 1 did not enable.
  always_ff @(posedge clk) begin
    if (wr_acc[1] & hit[1] & ~collide) begin
      for (int b = 0; b < BE_W; b++)
        if (be[1][b]) mem[idx[1]][8*b +: 8] <= wdata[1][8*b +: 8];
    end
    if (wr_acc[0] & hit[0]) begin
      for (int b = 0; b < BE_W; b++)
        if (be[0][b]) mem[idx[0]][8*b +: 8] <= wdata[0][8*b +: 8];
    end
  end

  // Stage p0: read capture at acceptance (pre-write data), frozen when en = 0
  logic [DATA_WIDTH-1:0] rdata_p0 [2];
  logic [1:0]            vld_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0      <= '0;
      rdata_p0[0] <= '0;
      rdata_p0[1] <= '0;
    end else if (en) begin
      vld_p0 <= rd_acc;
      for (int p = 0; p < 2; p++)
        if (rd_acc[p]) rdata_p0[p] <= hit[p] ? mem[idx[p]] : '0;
    end
  end

  logic [DATA_WIDTH-1:0] rdata_out [2];
  logic [1:0]            vld_out;

  if (READ_LATENCY == 2) begin : g_lat2
    // Stage p1: second register, also frozen when en = 0
    logic [DATA_WIDTH-1:0] rdata_p1 [2];
    logic [1:0]            vld_p1;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_p1      <= '0;
        rdata_p1[0] <= '0;
        rdata_p1[1] <= '0;
      end else if (en) begin
        vld_p1 <= vld_p0;
        for (int p = 0; p < 2; p++)
          if (vld_p0[p]) rdata_p1[p] <= rdata_p0[p];
      end
    end

    assign rdata_out[0] = rdata_p1[0];
    assign rdata_out[1] = rdata_p1[1];
    assign vld_out      = vld_p1;
  end else begin : g_lat1
    assign rdata_out[0] = rdata_p0[0];
    assign rdata_out[1] = rdata_p0[1];
    assign vld_out      = vld_p0;
  end

  // A frozen return stays pending in the pipeline; masking with en keeps the
  // strobe low during the stall and yields exactly one pulse once en returns.
  assign s1_readdata      = rdata_out[0];
  assign s2_readdata      = rdata_out[1];
  assign s1_readdatavalid = vld_out[0] & en;
  assign s2_readdatavalid = vld_out[1] & en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collision_count <= '0;
      oob_error       <= '0;
    end else begin
      if (collide) collision_count <= sat_inc(collision_count);
      oob_error <= oob_error | ((wr_acc | rd_acc) & ~hit);
    end
  end

endmodule

// File: tb/tb_onchip_ram_dual.sv
module tb_onchip_ram_dual;

  logic        clk, reset, reset_req, clken;
  logic [13:0] s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write;
  logic        s2_chipselect, s2_read, s2_write;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata;

  // [dut][port]: dut 0 has READ_LATENCY 1, dut 1 has READ_LATENCY 2
  logic [31:0] rdat [2][2];
  logic        vld  [2][2];
  logic [15:0] ccnt [2];
  logic [1:0]  oob  [2];

  onchip_ram_dual #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(rdat[0][0]), .s1_readdatavalid(vld[0][0]),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(rdat[0][1]), .s2_readdatavalid(vld[0][1]),
    .collision_count(ccnt[0]), .oob_error(oob[0])
  );

  onchip_ram_dual #(.READ_LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(rdat[1][0]), .s1_readdatavalid(vld[1][0]),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(rdat[1][1]), .s2_readdatavalid(vld[1][1]),
    .collision_count(ccnt[1]), .oob_error(oob[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          port;
    bit          is_wr;
    logic [13:0] addr;
    logic [3:0]  be;
    logic [31:0] data;   // write data, or expected read data
    string       nm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
  endtask

  task automatic drive(input int p, input bit w, input bit r, input logic [13:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (p == 1) begin
      s1_chipselect = 1'b1; s1_write = w; s1_read = r;
      s1_address = a; s1_byteenable = be; s1_writedata = d;
    end else begin
      s2_chipselect = 1'b1; s2_write = w; s2_read = r;
      s2_address = a; s2_byteenable = be; s2_writedata = d;
    end
  endtask

  // Called just after the acceptance edge: latency-1 return in this cycle,
  // latency-2 return in the next one.
  task automatic expect_ret(input int p, input logic [31:0] exp, input string nm);
    @(negedge clk);
    chk({nm, " l1 vld"}, 32'(vld[0][p-1]), 32'd1);
    chk({nm, " l1 data"}, rdat[0][p-1], exp);
    chk({nm, " l2 early vld"}, 32'(vld[1][p-1]), 32'd0);
    @(negedge clk);
    chk({nm, " l1 late vld"}, 32'(vld[0][p-1]), 32'd0);
    chk({nm, " l2 vld"}, 32'(vld[1][p-1]), 32'd1);
    chk({nm, " l2 data"}, rdat[1][p-1], exp);
  endtask

  task automatic rd(input int p, input logic [13:0] a, input logic [31:0] exp, input string nm);
    tick();
    drive(p, 1'b0, 1'b1, a, 4'h0, 32'h0);
    tick();
    idle();
    expect_ret(p, exp, nm);
  endtask

  task automatic wr(input int p, input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
    tick();
    drive(p, 1'b1, 1'b0, a, be, d);
    tick();
    idle();
  endtask

  task automatic chk_status(input logic [15:0] c, input logic [1:0] o, input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, " ccnt"}, 32'(ccnt[d]), 32'(c));
      chk({nm, " oob"}, 32'(oob[d]), 32'(o));
    end
  endtask

  task automatic collide_both(input logic [31:0] d1, input logic [31:0] d2);
    drive(1, 1'b1, 1'b0, 14'd7, 4'hF, d1);
    drive(2, 1'b1, 1'b0, 14'd7, 4'hF, d2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
    s1_address = '0; s2_address = '0; s1_byteenable = '0; s2_byteenable = '0;
    s1_writedata = '0; s2_writedata = '0;
    idle();

    vecs.push_back('{1, 1'b1, 14'd5,     4'h5, 32'h11223344, "wr5b"});
    vecs.push_back('{2, 1'b0, 14'd5,     4'h0, 32'hAA22CC44, "be rd5"});
    vecs.push_back('{2, 1'b1, 14'd0,     4'hF, 32'h00000010, "wr0"});
    vecs.push_back('{2, 1'b1, 14'd1,     4'hF, 32'h00000011, "wr1"});
    vecs.push_back('{1, 1'b1, 14'd2,     4'hF, 32'h00000012, "wr2"});
    vecs.push_back('{2, 1'b1, 14'd3,     4'h3, 32'hDEADBEEF, "wr3"});
    vecs.push_back('{1, 1'b0, 14'd3,     4'h0, 32'h0000BEEF, "be rd3"});
    vecs.push_back('{1, 1'b1, 14'd4,     4'hC, 32'h12345678, "wr4"});
    vecs.push_back('{2, 1'b0, 14'd4,     4'h0, 32'h12340000, "be rd4"});
    vecs.push_back('{1, 1'b0, 14'd6,     4'h0, 32'h00000000, "init rd6"});
    vecs.push_back('{2, 1'b1, 14'd5,     4'h8, 32'h99000000, "wr5c"});
    vecs.push_back('{1, 1'b0, 14'd5,     4'h0, 32'h9922CC44, "be rd5b"});
    vecs.push_back('{2, 1'b1, 14'd11999, 4'hF, 32'hCAFEF00D, "wr top"});
    vecs.push_back('{1, 1'b0, 14'd11999, 4'h0, 32'hCAFEF00D, "rd top"});
    vecs.push_back('{2, 1'b0, 14'd0,     4'h0, 32'h00000010, "rd0"});
    vecs.push_back('{1, 1'b0, 14'd1,     4'h0, 32'h00000011, "rd1"});

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        chk("reset vld", 32'(vld[d][p]), 32'd0);
        chk("reset data", rdat[d][p], 32'd0);
      end
    chk_status(16'd0, 2'b00, "reset");

    // First write presented in the first cycle with reset low
    tick();
    reset = 1'b0;
    drive(1, 1'b1, 1'b0, 14'd5, 4'hF, 32'hAABBCCDD);
    tick();
    idle();

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) wr(vecs[i].port, vecs[i].addr, vecs[i].be, vecs[i].data);
      else               rd(vecs[i].port, vecs[i].addr, vecs[i].data, vecs[i].nm);
    end

    // Back-to-back reads of 0, 1, 2 on port 1
    tick();
    drive(1, 1'b0, 1'b1, 14'd0, 4'h0, 32'h0);
    tick();
    drive(1, 1'b0, 1'b1, 14'd1, 4'h0, 32'h0);
    @(negedge clk);
    chk("b2b c1 l1 vld", 32'(vld[0][0]), 32'd1);
    chk("b2b c1 l1 data", rdat[0][0], 32'h10);
    chk("b2b c1 l2 vld", 32'(vld[1][0]), 32'd0);
    tick();
    drive(1, 1'b0, 1'b1, 14'd2, 4'h0, 32'h0);
    @(negedge clk);
    chk("b2b c2 l1 data", rdat[0][0], 32'h11);
    chk("b2b c2 l2 vld", 32'(vld[1][0]), 32'd1);
    chk("b2b c2 l2 data", rdat[1][0], 32'h10);
    tick();
    idle();
    @(negedge clk);
    chk("b2b c3 l1 vld", 32'(vld[0][0]), 32'd1);
    chk("b2b c3 l1 data", rdat[0][0], 32'h12);
    chk("b2b c3 l2 vld", 32'(vld[1][0]), 32'd1);
    chk("b2b c3 l2 data", rdat[1][0], 32'h11);
    tick();
    @(negedge clk);
    chk("b2b c4 l1 vld", 32'(vld[0][0]), 32'd0);
    chk("b2b c4 l2 vld", 32'(vld[1][0]), 32'd1);
    chk("b2b c4 l2 data", rdat[1][0], 32'h12);
    tick();
    @(negedge clk);
    chk("b2b hold l2 vld", 32'(vld[1][0]), 32'd0);
    chk("b2b hold l2 data", rdat[1][0], 32'h12);
    chk("b2b hold l1 data", rdat[0][0], 32'h12);

    // Same-address write collision
    tick();
    collide_both(32'h1, 32'h2);
    tick();
    idle();
    @(negedge clk);
    chk_status(16'd1, 2'b00, "coll1");
    rd(2, 14'd7, 32'h1, "coll rd7");

    // Different addresses in the same cycle are independent
    tick();
    drive(1, 1'b1, 1'b0, 14'd20, 4'hF, 32'hA1A1A1A1);
    drive(2, 1'b1, 1'b0, 14'd21, 4'hF, 32'hB2B2B2B2);
    tick();
    idle();
    @(negedge clk);
    chk_status(16'd1, 2'b00, "indep");
    rd(1, 14'd21, 32'hB2B2B2B2, "indep rd21");
    rd(2, 14'd20, 32'hA1A1A1A1, "indep rd20");

    // Read of an address written by the other port in the same cycle
    tick();
    drive(2, 1'b0, 1'b1, 14'd5, 4'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 14'd5, 4'hF, 32'h55555555);
    tick();
    idle();
    expect_ret(2, 32'h9922CC44, "rdw old");
    rd(2, 14'd5, 32'h55555555, "rdw new");

    // Read and write together: only the write happens
    tick();
    drive(1, 1'b1, 1'b1, 14'd30, 4'hF, 32'h00000077);
    tick();
    idle();
    @(negedge clk);
    chk("rw l1 no vld", 32'(vld[0][0]), 32'd0);
    @(negedge clk);
    chk("rw l2 no vld", 32'(vld[1][0]), 32'd0);
    rd(1, 14'd30, 32'h00000077, "rw rd30");

    // Saturate the collision counter: 1 + 65534 = 0xFFFF, then one more
    tick();
    collide_both(32'h3, 32'h4);
    repeat (65534) @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk_status(16'hFFFF, 2'b00, "sat");
    tick();
    collide_both(32'h5, 32'h6);
    tick();
    idle();
    @(negedge clk);
    chk_status(16'hFFFF, 2'b00, "sat hold");
    rd(1, 14'd7, 32'h5, "sat rd7");

    // Out of range
    wr(1, 14'd3808, 4'hF, 32'h38083808);
    wr(2, 14'd12000, 4'hF, 32'hFFFFFFFF);
    @(negedge clk);
    chk_status(16'hFFFF, 2'b10, "oob wr");
    rd(2, 14'd12000, 32'h0, "oob rd");
    rd(1, 14'd3808, 32'h38083808, "oob alias");
    chk_status(16'hFFFF, 2'b10, "oob sticky");
    rd(1, 14'd16383, 32'h0, "oob rd p1");
    chk_status(16'hFFFF, 2'b11, "oob both");

    // reset_req drops requests rather than queuing them
    tick();
    reset_req = 1'b1;
    drive(1, 1'b1, 1'b0, 14'd4, 4'hF, 32'hFFFFFFFF);
    drive(2, 1'b0, 1'b1, 14'd4, 4'h0, 32'h0);
    tick();
    idle();
    reset_req = 1'b0;
    @(negedge clk);
    chk("rreq l1 vld", 32'(vld[0][1]), 32'd0);
    @(negedge clk);
    chk("rreq l2 vld", 32'(vld[1][1]), 32'd0);
    rd(1, 14'd4, 32'h12340000, "rreq rd4");

    // clken stall of 3 cycles delays the return by 3 cycles
    tick();
    drive(1, 1'b0, 1'b1, 14'd4, 4'h0, 32'h0);
    tick();
    idle();
    clken = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall l1 vld", 32'(vld[0][0]), 32'd0);
      chk("stall l2 vld", 32'(vld[1][0]), 32'd0);
      tick();
    end
    clken = 1'b1;
    expect_ret(1, 32'h12340000, "stall ret");

    // Reset mid-flight flushes the pipeline but keeps memory
    tick();
    drive(1, 1'b0, 1'b1, 14'd2, 4'h0, 32'h0);
    tick();
    idle();
    reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst vld", 32'(vld[d][0]), 32'd0);
      chk("rst data", rdat[d][0], 32'd0);
    end
    chk_status(16'd0, 2'b00, "rst");
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post rst l1 vld", 32'(vld[0][0]), 32'd0);
    chk("post rst l2 vld", 32'(vld[1][0]), 32'd0);
    tick();
    @(negedge clk);
    chk("post rst l2 vld2", 32'(vld[1][0]), 32'd0);
    rd(1, 14'd5, 32'h55555555, "post rst rd5");
    rd(2, 14'd0, 32'h00000010, "post rst rd0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
